// File: rtl/gmii_rx_mac.sv
// GMII receive MAC: strips preamble/SFD, filters on destination address,
// delays the byte stream by five bytes so the FCS never reaches the user,
// and reports frame status (CRC, runt, oversize) alongside the last byte.
module gmii_rx_mac #(
   parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55
) (
   input  logic       gmii_rx_clk,
   input  logic       rst,
   input  logic       gmii_rx_dv,
   input  logic [7:0] gmii_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_sop,
   output logic       rx_eop,
   output logic       rx_frame_ok,
   output logic [1:0] rx_err_code
);

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [10:0] MIN_LEN     = 11'd64;
   localparam logic [10:0] MAX_LEN     = 11'd1518;
   localparam logic [10:0] HDR_LAST    = 11'd5;

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   state_t      state, state_nx;
   logic [3:0]  pre_cnt, pre_cnt_nx;
   logic [10:0] byte_cnt, byte_cnt_nx;
   logic [31:0] crc, crc_nx;

   logic [7:0]  data_nx;
   logic        valid_nx, sop_nx, eop_nx, ok_nx;
   logic [1:0]  err_nx;

   // five-byte delay line; sh_p4 is the oldest byte
   logic [7:0]  sh_p0, sh_p1, sh_p2, sh_p3, sh_p4;
   logic        shift_en;
   logic [47:0] dest;
   logic        dest_match;

   // Reflected CRC-32 update over one byte, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   // Byte counter saturates rather than wrapping on jumbo/garbage frames.
   function automatic logic [10:0] sat_inc(input logic [10:0] c);
      return (c == 11'h7FF) ? c : c + 11'd1;
   endfunction

   // Status priority: runt, then oversize, then CRC.
   function automatic logic [1:0] frame_status(input logic [10:0] len, input logic [31:0] c);
      if (len < MIN_LEN)          return 2'd2;
      else if (len > MAX_LEN)     return 2'd3;
      else if (c != CRC_RESIDUE)  return 2'd1;
      else                        return 2'd0;
   endfunction

   assign shift_en   = (state == DATA) && gmii_rx_dv;
   // bytes 0..4 sit in the delay line when byte 5 arrives on gmii_rxd
   assign dest       = {sh_p4, sh_p3, sh_p2, sh_p1, sh_p0, gmii_rxd};
   assign dest_match = (dest == BOARD_MAC) || (dest == 48'hFFFF_FFFF_FFFF);

   // Next-state, counters, CRC and the next output word.
   always_comb begin
      state_nx    = state;
      pre_cnt_nx  = pre_cnt;
      byte_cnt_nx = byte_cnt;
      crc_nx      = crc;
      data_nx     = rx_data;
      valid_nx    = 1'b0;
      sop_nx      = 1'b0;
      eop_nx      = 1'b0;
      ok_nx       = 1'b0;
      err_nx      = 2'd0;
      case (state)
         IDLE: begin
            crc_nx      = CRC_INIT;
            byte_cnt_nx = 11'd0;
            if (gmii_rx_dv) begin
               if (gmii_rxd == 8'h55) begin
                  state_nx   = PREAMBLE;
                  pre_cnt_nx = 4'd1;
               end else begin
                  state_nx = DROP;
               end
            end
         end
         PREAMBLE: begin
            crc_nx      = CRC_INIT;
            byte_cnt_nx = 11'd0;
            if (!gmii_rx_dv) begin
               state_nx = IDLE;
            end else if (gmii_rxd == 8'h55) begin
               pre_cnt_nx = (pre_cnt == 4'hF) ? pre_cnt : pre_cnt + 4'd1;
            end else if (gmii_rxd == 8'hD5 && pre_cnt >= 4'd1 && pre_cnt <= 4'd7) begin
               state_nx = DATA;
            end else begin
               state_nx = DROP;
            end
         end
         DATA: begin
            if (gmii_rx_dv) begin
               crc_nx      = crc32_byte(crc, gmii_rxd);
               byte_cnt_nx = sat_inc(byte_cnt);
               if (byte_cnt == HDR_LAST) begin
                  if (dest_match) begin
                     valid_nx = 1'b1;
                     sop_nx   = 1'b1;
                     data_nx  = sh_p4;
                  end else begin
                     state_nx = DROP;
                  end
               end else if (byte_cnt > HDR_LAST) begin
                  valid_nx = 1'b1;
                  data_nx  = sh_p4;
               end
            end else begin
               // frames shorter than the address field vanish silently
               state_nx = IDLE;
               if (byte_cnt > HDR_LAST) begin
                  valid_nx = 1'b1;
                  eop_nx   = 1'b1;
                  data_nx  = sh_p4;
                  err_nx   = frame_status(byte_cnt, crc);
                  ok_nx    = (err_nx == 2'd0);
               end
            end
         end
         DROP: begin
            crc_nx      = CRC_INIT;
            byte_cnt_nx = 11'd0;
            if (!gmii_rx_dv) state_nx = IDLE;
         end
         default: state_nx = DROP;
      endcase
   end

   // Control state and registered outputs; reset parks the FSM in DROP.
   always_ff @(posedge gmii_rx_clk) begin
      if (rst) begin
         state       <= DROP;
         pre_cnt     <= 4'd0;
         byte_cnt    <= 11'd0;
         crc         <= CRC_INIT;
         rx_data     <= 8'd0;
         rx_valid    <= 1'b0;
         rx_sop      <= 1'b0;
         rx_eop      <= 1'b0;
         rx_frame_ok <= 1'b0;
         rx_err_code <= 2'd0;
      end else begin
         state       <= state_nx;
         pre_cnt     <= pre_cnt_nx;
         byte_cnt    <= byte_cnt_nx;
         crc         <= crc_nx;
         rx_data     <= data_nx;
         rx_valid    <= valid_nx;
         rx_sop      <= sop_nx;
         rx_eop      <= eop_nx;
         rx_frame_ok <= ok_nx;
         rx_err_code <= err_nx;
      end
   end

   // Delay line p0 -> p4; validity is tracked by byte_cnt, so no reset here.
   always_ff @(posedge gmii_rx_clk) begin
      if (shift_en) begin
         sh_p0 <= gmii_rxd;
         sh_p1 <= sh_p0;
         sh_p2 <= sh_p1;
         sh_p3 <= sh_p2;
         sh_p4 <= sh_p3;
      end
   end

endmodule

// File: tb/tb_gmii_rx_mac.sv
// Directed bench for gmii_rx_mac: frames are built with a locally computed
// FCS, driven byte by byte, and the output stream is captured per frame.
module tb_gmii_rx_mac;

   localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;

   logic       gmii_rx_clk;
   logic       rst;
   logic       gmii_rx_dv;
   logic [7:0] gmii_rxd;
   logic [7:0] rx_data;
   logic       rx_valid, rx_sop, rx_eop, rx_frame_ok;
   logic [1:0] rx_err_code;

   gmii_rx_mac #(.BOARD_MAC(MAC)) dut (
      .gmii_rx_clk(gmii_rx_clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
      .rx_frame_ok(rx_frame_ok), .rx_err_code(rx_err_code)
   );

   initial begin
      gmii_rx_clk = 1'b0;
      forever #5 gmii_rx_clk = ~gmii_rx_clk;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic rst_q = 1'b1;

   logic [7:0] fb [2][2048];
   int flen [2];
   int b0_cyc;

   // monitor state
   int mbuf, n_valid, sop_cnt, sop_idx, eop_cnt, eop_idx, data_bad, stray, rst_viol, first_cyc;
   int m_err, m_ok;

   always @(posedge gmii_rx_clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   // Capture the output stream of the current frame.
   always @(negedge gmii_rx_clk) begin
      if (rst_q && ({rx_data, rx_valid, rx_sop, rx_eop, rx_frame_ok, rx_err_code} != 14'd0))
         rst_viol++;
      if (!rx_valid && (rx_sop || rx_eop || rx_frame_ok || rx_err_code != 2'd0)) stray++;
      if (rx_valid && !rx_eop && (rx_frame_ok || rx_err_code != 2'd0)) stray++;
      if (rx_valid) begin
         if (first_cyc < 0) first_cyc = cyc;
         if (n_valid < 2048 && rx_data != fb[mbuf][n_valid]) data_bad++;
         if (rx_sop) begin sop_cnt++; sop_idx = n_valid; end
         if (rx_eop) begin
            eop_cnt++; eop_idx = n_valid;
            m_err = int'(rx_err_code); m_ok = int'(rx_frame_ok);
         end
         n_valid++;
      end
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'd0, d};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic build(input int sel, input logic [47:0] dst, input int len, input bit flip);
      logic [31:0] c;
      logic [47:0] src;
      src = 48'h02_AA_BB_CC_DD_EE;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 6; i++) fb[sel][i] = dst[47-8*i -: 8];
      for (int i = 0; i < 6; i++) fb[sel][6+i] = src[47-8*i -: 8];
      for (int i = 12; i < len - 4; i++) fb[sel][i] = 8'((i * 7 + 3) & 255);
      for (int i = 0; i < len - 4; i++) c = crc_upd(c, fb[sel][i]);
      c = ~c;
      for (int i = 0; i < 4; i++) fb[sel][len-4+i] = c[8*i +: 8];
      if (flip) fb[sel][20] = fb[sel][20] ^ 8'h04;
      flen[sel] = len;
   endtask

   task automatic drive(input logic dv, input logic [7:0] d);
      @(posedge gmii_rx_clk);
      #1;
      gmii_rx_dv = dv;
      gmii_rxd   = d;
   endtask

   // npre x 55, then sfd, then frame bytes (first 'stop' only if stop>=0), then dv=0.
   task automatic send(input int sel, input int npre, input logic [7:0] sfd, input int stop, input int rst_at);
      int n;
      for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
      drive(1'b1, sfd);
      n = (stop >= 0) ? stop : flen[sel];
      for (int i = 0; i < n; i++) begin
         drive(1'b1, fb[sel][i]);
         if (i == 0) b0_cyc = cyc;
         if (i == rst_at) rst = 1'b1;
         if (i == rst_at + 3) rst = 1'b0;
      end
      drive(1'b0, 8'h00);
   endtask

   task automatic clear_mon(input int sel);
      mbuf = sel; n_valid = 0; sop_cnt = 0; sop_idx = -1; eop_cnt = 0; eop_idx = -1;
      data_bad = 0; stray = 0; rst_viol = 0; first_cyc = -1; m_err = 0; m_ok = 0;
   endtask

   task automatic settle();
      repeat (3) @(negedge gmii_rx_clk);
      #1;
   endtask

   task automatic check_frame(input string nm, input int exp_n, input int exp_err, input int exp_ok);
      chk({nm, "/count"}, n_valid, exp_n);
      chk({nm, "/eop_cnt"}, eop_cnt, (exp_n > 0) ? 1 : 0);
      chk({nm, "/sop_cnt"}, sop_cnt, (exp_n > 0) ? 1 : 0);
      chk({nm, "/data"}, data_bad, 0);
      chk({nm, "/stray"}, stray, 0);
      if (exp_n > 0) begin
         chk({nm, "/sop_idx"}, sop_idx, 0);
         chk({nm, "/eop_idx"}, eop_idx, exp_n - 1);
         chk({nm, "/err"}, m_err, exp_err);
         chk({nm, "/ok"}, m_ok, exp_ok);
      end
   endtask

   typedef struct {
      string       name;
      int          npre;
      logic [47:0] dst;
      int          len;
      bit          flip;
      int          exp_n;
      int          exp_err;
      int          exp_ok;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{"crc_bad",   7, MAC,   64,   1'b1, 60,   1, 0};
      vecs[1] = '{"bcast_runt",7, BCAST, 60,   1'b0, 56,   2, 0};
      vecs[2] = '{"other_dst", 7, OTHER, 64,   1'b0, 0,    0, 0};
      vecs[3] = '{"max_len",   7, MAC,   1518, 1'b0, 1514, 0, 1};
      vecs[4] = '{"over_1519", 7, MAC,   1519, 1'b0, 1515, 3, 0};
      vecs[5] = '{"pre_one",   1, MAC,   65,   1'b0, 61,   0, 1};
      vecs[6] = '{"pre_eight", 8, MAC,   64,   1'b0, 0,    0, 0};
      vecs[7] = '{"bcast_ok",  7, BCAST, 64,   1'b0, 60,   0, 1};

      rst = 1'b1; gmii_rx_dv = 1'b1; gmii_rxd = 8'h55;
      clear_mon(0);
      repeat (4) @(posedge gmii_rx_clk);
      @(negedge gmii_rx_clk);
      chk("reset/valid", int'(rx_valid), 0);
      chk("reset/data", int'(rx_data), 0);
      chk("reset/eop", int'(rx_eop), 0);
      chk("reset/err", int'(rx_err_code), 0);

      // release reset mid-frame: the remainder must be discarded
      build(0, MAC, 64, 1'b0);
      #1; rst = 1'b0;
      drive(1'b1, 8'hD5);
      for (int i = 0; i < 64; i++) drive(1'b1, fb[0][i]);
      drive(1'b0, 8'h00);
      settle();
      chk("post_reset/rst_viol", rst_viol, 0);
      check_frame("post_reset", 0, 0, 0);

      // reference good frame with latency check
      clear_mon(0);
      send(0, 7, 8'hD5, -1, -1);
      settle();
      check_frame("good64", 60, 0, 1);
      chk("good64/latency", first_cyc - b0_cyc, 6);

      for (int v = 0; v < 8; v++) begin
         build(0, vecs[v].dst, vecs[v].len, vecs[v].flip);
         clear_mon(0);
         send(0, vecs[v].npre, 8'hD5, -1, -1);
         settle();
         check_frame(vecs[v].name, vecs[v].exp_n, vecs[v].exp_err, vecs[v].exp_ok);
      end

      // oversize 1522 then a good frame after a single idle cycle
      build(0, MAC, 1522, 1'b0);
      build(1, MAC, 64, 1'b0);
      clear_mon(0);
      send(0, 7, 8'hD5, -1, -1);
      fork
         send(1, 7, 8'hD5, -1, -1);
         begin
            repeat (2) @(negedge gmii_rx_clk);
            #1;
            check_frame("over_1522", 1518, 3, 0);
            clear_mon(1);
         end
      join
      settle();
      check_frame("b2b_good", 60, 0, 1);

      // malformed preambles and a truncated frame, each followed by a good one
      build(1, MAC, 64, 1'b0);
      clear_mon(1); send(1, 2, 8'hAA, -1, -1); settle(); check_frame("pre_55_55_AA", 0, 0, 0);
      clear_mon(1); send(1, 9, 8'hD5, -1, -1); settle(); check_frame("pre_9x55", 0, 0, 0);
      clear_mon(1); send(1, 7, 8'hD5, 4, -1);  settle(); check_frame("short_4", 0, 0, 0);
      clear_mon(1); send(1, 7, 8'hD5, -1, -1); settle(); check_frame("after_bad", 60, 0, 1);

      // reset pulsed at byte 30: bytes 0..24 came out, no eop
      build(0, MAC, 100, 1'b0);
      clear_mon(0);
      send(0, 7, 8'hD5, -1, 30);
      settle();
      chk("rst_mid/count", n_valid, 25);
      chk("rst_mid/eop", eop_cnt, 0);
      chk("rst_mid/rst_viol", rst_viol, 0);
      chk("rst_mid/stray", stray, 0);
      clear_mon(0);
      send(0, 7, 8'hD5, -1, -1);
      settle();
      check_frame("after_rst", 96, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gmii_rx_mac.md
GMII_RX_MAC -- requirements
Module: gmii_rx_mac

Interface
REQ-001 SHALL have parameter BOARD_MAC, default 48'h00_11_22_33_44_55: the station address accepted as destination MAC; byte 0 is the first byte on the wire.
REQ-002 SHALL have port gmii_rx_clk, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port gmii_rx_dv, input, 1: GMII receive data valid.
REQ-005 SHALL have port gmii_rxd, input, 8: GMII receive byte.
REQ-006 SHALL have port rx_data, output, 8: frame byte with preamble, SFD and FCS removed.
REQ-007 SHALL have port rx_valid, output, 1: rx_data holds a frame byte.
REQ-008 SHALL have port rx_sop, output, 1: first byte of the frame (destination MAC byte 0), qualified by rx_valid.
REQ-009 SHALL have port rx_eop, output, 1: last non-FCS byte, qualified by rx_valid.
REQ-010 SHALL have port rx_frame_ok, output, 1: frame passed all checks; valid only with rx_eop.
REQ-011 SHALL have port rx_err_code, output, 2: cause of failure, valid with rx_eop: 0 none, 1 CRC, 2 runt, 3 oversize.

Function
REQ-012 SHALL implement the states IDLE, PREAMBLE, DATA and DROP.
REQ-013 IDLE: dv=1 and rxd=8'h55 -> PREAMBLE, with the preamble count set to 1; dv=1 and any other byte -> DROP; dv=0 -> stay in IDLE.
REQ-014 PREAMBLE: 8'h55 -> increment the count; 8'hD5 with count 1..7 -> DATA; 8'hD5 with count >7, or any other byte -> DROP; dv=0 -> IDLE.
REQ-015 DROP: ignore all input; dv=0 -> IDLE.
REQ-016 DATA: every dv=1 byte is frame byte k (k=0 is the first byte after the SFD) and increments an 11-bit byte counter that saturates at 2047; dv=0 ends the frame with length L = count -> IDLE.
REQ-017 The destination MAC is bytes 0..5. The frame is accepted if they equal BOARD_MAC or 48'hFF_FF_FF_FF_FF_FF; otherwise -> DROP with no rx_valid ever asserted for that frame.
REQ-018 A frame whose dv falls before byte 5 is sampled SHALL be discarded silently: no outputs, return to IDLE.
REQ-019 Output latency: byte k SHALL be driven on rx_data/rx_valid in the cycle after the edge that samples byte k+5. The dv=0 edge that ends the frame counts as position L, so bytes L-4..L-1 (the FCS) are never output.
REQ-020 rx_sop SHALL be 1 with byte 0 only; rx_eop SHALL be 1 with byte L-5 only; an accepted frame with L<6 cannot occur (REQ-018).
REQ-021 CRC SHALL be CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) computed over bytes 0..L-1. The frame passes the CRC check iff the final register equals 32'hDEBB20E3.
REQ-022 Error priority at rx_eop: L<64 -> 2 (runt); else L>1518 -> 3 (oversize); else CRC fail -> 1; else 0.
REQ-023 rx_frame_ok SHALL equal (rx_err_code==0) && rx_eop; both SHALL be 0 when rx_eop=0.
REQ-024 A frame with L>1518 SHALL still output all bytes; only its status reports the error.
REQ-025 No inter-frame gap minimum SHALL be required: the cycle after the terminating dv=0, the block SHALL accept a new preamble in IDLE.
REQ-026 Block throughput SHALL be one byte per cycle with no backpressure.

Reset
REQ-027 While rst=1, all outputs SHALL be 0, the CRC register SHALL be 32'hFFFFFFFF, counters SHALL be 0, and the shift pipeline SHALL be invalidated.
REQ-028 Reset SHALL leave the FSM in DROP, so a frame in progress when reset is released is discarded until dv=0.
REQ-029 No partial rx_eop or status SHALL be output for a frame cut by reset.

Verification
REQ-030 7x 55, D5, then a 64-byte frame to BOARD_MAC with a valid FCS -> 60 rx_valid bytes; sop with byte 0, eop with byte 59, rx_frame_ok=1, err=0; first rx_valid 6 cycles after the byte-0 edge.
REQ-031 The same frame with one payload bit flipped -> 60 bytes output, eop with rx_frame_ok=0, err=1.
REQ-032 A broadcast frame of L=60 with a valid CRC -> 56 bytes output, err=2; a frame to 02:00:00:00:00:01 -> no rx_valid at all.
REQ-033 L=1522 to BOARD_MAC with a valid CRC -> 1518 bytes output, err=3; then a back-to-back frame with one idle cycle -> the second frame is received OK.
REQ-034 Malformed preambles: preamble 55 55 AA, preamble of 9x 55 then D5, and dv dropped after byte 3 -> no outputs, and a following good frame is received OK.
REQ-035 rst pulsed at byte 30 of a frame -> outputs 0 during reset and no eop for that frame; the next good frame gives rx_frame_ok=1.
